// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller.
//  - scan_state_t : scan FSM states (IDLE / BLANK / DRIVE)
//  - SEG_0..SEG_F : active-low segment patterns, bit order {a,b,c,d,e,f,g}
//  - SEG_OFF      : full cathode byte with every segment and the decimal point dark
//  - hex_to_seg() : nibble -> 7-segment pattern, defined for all 16 codes
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to seven-segment decoder.
//  nibble : 4-bit hex code
//  seg    : active-low segments {a,b,c,d,e,f,g}
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Scan scheduler for a multiplexed seven-segment display.
//  Clk, Reset_n : clock, asynchronous active-low reset
//  digits_in    : hex nibble per digit (digit i = [4i+3:4i])
//  dp_in        : decimal point per digit, 1 = lit
//  dig_en_in    : digit enable, 1 = digit takes part in the scan
//  upd_req      : producer request to load digits_in/dp_in/dig_en_in
//  upd_ack      : 1-cycle pulse, shadow image captured on the edge that raised it
//  An           : anodes, active-low, at most one low
//  Cath         : {a,b,c,d,e,f,g,dp}, active-low
//  cur_digit    : digit owning the current slot
//  frame_start  : pulse at count 0 of each frame's first slot
//  dbg_state    : current scan FSM state
//
// Handshake: upd_req acts as "valid" and must stay high with stable data until
// upd_ack is seen. The controller is "ready" only in IDLE or at a frame
// boundary; the shadow image loads on the same edge that raises upd_ack. A
// request still high in the ack cycle is not counted again; if it stays high
// after that it is a fresh request.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int N_DIG     = 8,
  parameter int TICK_DIV  = 262144,
  parameter int BLANK_CYC = 1024
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [4*N_DIG-1:0] digits_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   dig_en_in,
  input  logic               upd_req,
  output logic               upd_ack,
  output logic [N_DIG-1:0]   An,
  output logic [7:0]         Cath,
  output logic [2:0]         cur_digit,
  output logic               frame_start,
  output scan_state_t        dbg_state
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  scan_state_t        state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [2:0]         cur, cur_nxt;
  logic [4*N_DIG-1:0] sh_dig, sh_dig_nxt;
  logic [N_DIG-1:0]   sh_dp, sh_dp_nxt;
  logic [N_DIG-1:0]   sh_en, sh_en_nxt;
  logic               ack_nxt, fs_nxt;
  logic [N_DIG-1:0]   an_nxt;
  logic [7:0]         cath_nxt;
  logic [3:0]         nib;
  logic               dp_bit;
  logic [6:0]         seg;
  logic [2:0]         next_idx;
  logic               take, slot_end, frame_end;

  function automatic logic [2:0] lowest_en(input logic [N_DIG-1:0] en);
    lowest_en = 3'd0;
    for (int i = N_DIG - 1; i >= 0; i--)
      if (en[i]) lowest_en = 3'(i);
  endfunction

  // Lowest enabled index above pos; falls back to the lowest enabled index.
  function automatic logic [2:0] next_en(input logic [N_DIG-1:0] en, input logic [2:0] pos);
    next_en = lowest_en(en);
    for (int i = N_DIG - 1; i >= 0; i--)
      if (en[i] && (3'(i) > pos)) next_en = 3'(i);
  endfunction

  // The ack cycle itself never counts as a new request.
  assign take      = upd_req && !upd_ack;
  assign slot_end  = (state != ST_IDLE) && (cnt == CNT_MAX);
  assign next_idx  = next_en(sh_en, cur);
  assign frame_end = slot_end && (next_idx <= cur);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cur_nxt    = cur;
    sh_dig_nxt = sh_dig;
    sh_dp_nxt  = sh_dp;
    sh_en_nxt  = sh_en;
    ack_nxt    = 1'b0;
    fs_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        cur_nxt = 3'd0;
        if (take) begin
          sh_dig_nxt = digits_in;
          sh_dp_nxt  = dp_in;
          sh_en_nxt  = dig_en_in;
          ack_nxt    = 1'b1;
          if (dig_en_in != '0) begin
            state_nxt = ST_BLANK;
            cur_nxt   = lowest_en(dig_en_in);
            fs_nxt    = 1'b1;
          end
        end
      end
      default: begin
        if (slot_end) begin
          cnt_nxt   = '0;
          state_nxt = ST_BLANK;
          cur_nxt   = next_idx;
          fs_nxt    = frame_end;
          if (take && frame_end) begin
            sh_dig_nxt = digits_in;
            sh_dp_nxt  = dp_in;
            sh_en_nxt  = dig_en_in;
            ack_nxt    = 1'b1;
            if (dig_en_in == '0) begin
              state_nxt = ST_IDLE;
              cur_nxt   = 3'd0;
              fs_nxt    = 1'b0;
            end else begin
              cur_nxt = lowest_en(dig_en_in);
            end
          end
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = (cnt_nxt >= CNT_BLANK) ? ST_DRIVE : ST_BLANK;
        end
      end
    endcase
  end

  // Pin values are computed from the next-cycle state so the registered
  // outputs line up with the count they belong to.
  always_comb begin
    an_nxt = '1;
    nib    = 4'd0;
    dp_bit = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (3'(i) == cur_nxt) begin
        nib    = sh_dig_nxt[4*i +: 4];
        dp_bit = sh_dp_nxt[i];
        if (state_nxt == ST_DRIVE) an_nxt[i] = 1'b0;
      end
    end
  end

  ssd_hex_decoder u_dec (
    .nibble (nib),
    .seg    (seg)
  );

  assign cath_nxt = (state_nxt == ST_DRIVE) ? {seg, ~dp_bit} : SEG_OFF;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cur         <= 3'd0;
      sh_dig      <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
      An          <= '1;
      Cath        <= SEG_OFF;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cur         <= cur_nxt;
      sh_dig      <= sh_dig_nxt;
      sh_dp       <= sh_dp_nxt;
      sh_en       <= sh_en_nxt;
      upd_ack     <= ack_nxt;
      frame_start <= fs_nxt;
      An          <= an_nxt;
      Cath        <= cath_nxt;
    end
  end

  assign cur_digit = cur;
  assign dbg_state = state;

endmodule
